// File: rtl/alu_mc_pkg.sv
// Shared types and constants for the multi-cycle ALU: opcode and FSM state
// enums plus the LINK offset and opcode width.
package alu_mc_pkg;

  localparam int OP_W        = 4;
  localparam int LINK_OFFSET = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_PASS  = 4'd5,
    OP_LINK  = 4'd6,
    OP_SLL   = 4'd7,
    OP_SRL   = 4'd8,
    OP_SRA   = 4'd9,
    OP_SLT   = 4'd10,
    OP_SLTU  = 4'd11,
    OP_MUL   = 4'd12,
    OP_MULHU = 4'd13,
    OP_DIVU  = 4'd14,
    OP_REMU  = 4'd15
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_mc_seq.sv
// Shared one-bit-per-cycle iterative unit: shift-add multiply and, when
// ALU_MC_DIV_EN is defined, restoring divide over the same 2*WIDTH accumulator.
module alu_mc_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
`ifdef ALU_MC_DIV_EN
  input  logic               start_div,
`endif
  input  logic               stall,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               done,
  output logic [2*WIDTH-1:0] acc_next
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               last;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
`ifdef ALU_MC_DIV_EN
  logic               div_q, div_d;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_sub;
  logic [2*WIDTH-1:0] div_step;
`endif

  // Multiply: upper half accumulates the multiplicand, multiplier shifts out of the low half.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_step = {mul_sum, acc_q[WIDTH-1:1]};
  end

`ifdef ALU_MC_DIV_EN
  // Divide: upper half is the partial remainder, lower half shifts dividend out and quotient in.
  always_comb begin
    rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, opnd_q};
    if (rem_sub[WIDTH]) begin
      div_step = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      div_step = {rem_sub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
  end

  assign acc_next = div_q ? div_step : mul_step;
`else
  assign acc_next = mul_step;
`endif

  assign last = (cnt_q == CNT_W'(WIDTH - 1));
  // The final step is held back while the output register still owns an unconsumed result.
  assign done = busy_q && last && !stall;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    opnd_d = opnd_q;
`ifdef ALU_MC_DIV_EN
    div_d  = div_q;
`endif
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
`ifdef ALU_MC_DIV_EN
      div_d  = start_div;
      acc_d  = {{WIDTH{1'b0}}, (start_div ? op_a : op_b)};
      opnd_d = start_div ? op_b : op_a;
`else
      acc_d  = {{WIDTH{1'b0}}, op_b};
      opnd_d = op_a;
`endif
    end else if (busy_q && !(last && stall)) begin
      acc_d = acc_next;
      if (last) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      opnd_q <= '0;
`ifdef ALU_MC_DIV_EN
      div_q  <= 1'b0;
`endif
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
`ifdef ALU_MC_DIV_EN
      div_q  <= div_d;
`endif
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU with valid/ready handshakes and a one-deep
// registered output. Define ALU_MC_DIV_EN to build the DIVU/REMU divider.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] out_tag,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             illegal
);

  localparam int SH_W = $clog2(WIDTH);

  alu_state_t         state_q, state_d, iter_state;
  logic               sel_hi_q, sel_hi_d;
  logic [TAG_W-1:0]   iter_tag_q, iter_tag_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;
  logic               zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d, illegal_q, illegal_d;

  alu_op_t            op_e;
  logic               transfer, is_mul, start_iter, wr_simple, seq_done, stall;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   iter_res;
  logic [WIDTH:0]     add_w, sub_w;
  logic [SH_W-1:0]    shamt;
  logic [WIDTH-1:0]   s_res;
  logic               s_carry, s_ovf, s_ill;

  assign op_e     = alu_op_t'(op);
  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign transfer = in_valid && in_ready;
  assign is_mul   = (op_e == OP_MUL) || (op_e == OP_MULHU);
  assign stall    = out_valid_q && !out_ready;

`ifdef ALU_MC_DIV_EN
  logic is_div;
  assign is_div     = ((op_e == OP_DIVU) || (op_e == OP_REMU)) && (b != '0);
  assign start_iter = transfer && (is_mul || is_div);
  assign iter_state = is_div ? ST_DIV : ST_MUL;
`else
  assign start_iter = transfer && is_mul;
  assign iter_state = ST_MUL;
`endif
  assign wr_simple = transfer && !start_iter;

  // Odd iterative opcodes (MULHU, REMU) take the upper accumulator half.
  assign iter_res = sel_hi_q ? acc_next[2*WIDTH-1:WIDTH] : acc_next[WIDTH-1:0];

  alu_mc_seq #(.WIDTH(WIDTH)) u_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_iter),
`ifdef ALU_MC_DIV_EN
    .start_div(is_div),
`endif
    .stall    (stall),
    .op_a     (a),
    .op_b     (b),
    .done     (seq_done),
    .acc_next (acc_next)
  );

  always_comb begin
    add_w   = {1'b0, a} + {1'b0, b};
    sub_w   = {1'b0, a} - {1'b0, b};
    shamt   = b[SH_W-1:0];
    s_res   = '0;
    s_carry = 1'b0;
    s_ovf   = 1'b0;
    s_ill   = 1'b0;
    case (op_e)
      OP_ADD: begin
        s_res   = add_w[WIDTH-1:0];
        s_carry = add_w[WIDTH];
        s_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        s_res   = sub_w[WIDTH-1:0];
        s_carry = ~sub_w[WIDTH];
        s_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  s_res = a & b;
      OP_OR:   s_res = a | b;
      OP_XOR:  s_res = a ^ b;
      OP_PASS: s_res = a;
      OP_LINK: s_res = a + WIDTH'(LINK_OFFSET);
      OP_SLL:  s_res = a << shamt;
      OP_SRL:  s_res = a >> shamt;
      OP_SRA:  s_res = $signed(a) >>> shamt;
      OP_SLT:  s_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: s_res = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef ALU_MC_DIV_EN
      // Only reached with b == 0; nonzero divisors go to the iterative unit.
      OP_DIVU: s_res = '1;
      OP_REMU: s_res = a;
`else
      OP_DIVU: s_ill = 1'b1;
      OP_REMU: s_ill = 1'b1;
`endif
      default: s_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:        if (start_iter) state_d = iter_state;
      ST_MUL, ST_DIV: if (seq_done) state_d = ST_IDLE;
      default:        state_d = ST_IDLE;
    endcase
  end

  // Output register: a new result overwrites, otherwise out_ready drains it.
  always_comb begin
    sel_hi_d    = sel_hi_q;
    iter_tag_d  = iter_tag_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    out_tag_d   = out_tag_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    illegal_d   = illegal_q;
    if (start_iter) begin
      sel_hi_d   = op[0];
      iter_tag_d = in_tag;
    end
    if (wr_simple) begin
      out_valid_d = 1'b1;
      result_d    = s_res;
      out_tag_d   = in_tag;
      zero_d      = (s_res == '0);
      carry_d     = s_carry;
      ovf_d       = s_ovf;
      illegal_d   = s_ill;
    end else if (seq_done) begin
      out_valid_d = 1'b1;
      result_d    = iter_res;
      out_tag_d   = iter_tag_q;
      zero_d      = (iter_res == '0);
      carry_d     = 1'b0;
      ovf_d       = 1'b0;
      illegal_d   = 1'b0;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sel_hi_q    <= 1'b0;
      iter_tag_q  <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      out_tag_q   <= '0;
      zero_q      <= 1'b1;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_hi_q    <= sel_hi_d;
      iter_tag_q  <= iter_tag_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      out_tag_q   <= out_tag_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign out_tag   = out_tag_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc (WIDTH=32); expectations follow
// ALU_MC_DIV_EN so the same bench covers both builds.
module tb_alu_mc;

  localparam int WIDTH = 32;
  localparam int TAG_W = 5;
`ifdef ALU_MC_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [TAG_W-1:0] out_tag;
  logic             zero;
  logic             carry;
  logic             ovf;
  logic             illegal;

  int testsRun;
  int testsFailed;
  int extraEdges;
  bit readyLowOk;

  alu_mc #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .out_tag  (out_tag),
    .zero     (zero),
    .carry    (carry),
    .ovf      (ovf),
    .illegal  (illegal)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge so sampling is clear of it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Present one operation, transfer it, then count edges until out_valid (bounded).
  task automatic applyStimulus(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                               input logic [4:0] t, output int extra, output bit rdyLow);
    op       = o;
    a        = x;
    b        = y;
    in_tag   = t;
    in_valid = 1'b1;
    checkOutput("accept", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    extra    = 0;
    rdyLow   = 1'b1;
    while (!out_valid && extra < 100) begin
      if (in_ready) rdyLow = 1'b0;
      tick();
      extra++;
    end
  endtask

  // Check a completed op's result, flags, tag and latency.
  task automatic checkOp(input string name, input logic [31:0] expRes, input logic expCarry,
                         input logic expOvf, input logic expIll, input logic [4:0] expTag,
                         input int expExtra);
    checkOutput({name, " result"}, 64'(result), 64'(expRes));
    checkOutput({name, " zero"}, 64'(zero), 64'(expRes == 32'd0));
    checkOutput({name, " carry"}, 64'(carry), 64'(expCarry));
    checkOutput({name, " ovf"}, 64'(ovf), 64'(expOvf));
    checkOutput({name, " illegal"}, 64'(illegal), 64'(expIll));
    checkOutput({name, " tag"}, 64'(out_tag), 64'(expTag));
    checkOutput({name, " latency"}, 64'(extraEdges), 64'(expExtra));
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    a           = '0;
    b           = '0;
    op          = '0;
    in_tag      = '0;

    repeat (3) tick();
    checkOutput("rst out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst result", 64'(result), 64'd0);
    checkOutput("rst zero", 64'(zero), 64'd1);
    checkOutput("rst out_tag", 64'(out_tag), 64'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("rst in_ready", 64'(in_ready), 64'd1);

    // Add/sub edge cases and flags
    applyStimulus(4'd0, 32'hFFFF_FFFF, 32'h1, 5'd1, extraEdges, readyLowOk);
    checkOp("ADD wrap", 32'h0, 1'b1, 1'b0, 1'b0, 5'd1, 0);
    applyStimulus(4'd1, 32'h8000_0000, 32'h1, 5'd2, extraEdges, readyLowOk);
    checkOp("SUB ovf", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 5'd2, 0);
    applyStimulus(4'd1, 32'h3, 32'h5, 5'd3, extraEdges, readyLowOk);
    checkOp("SUB borrow", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 5'd3, 0);

    // Back-to-back logic, pass, shifts, compares and link
    applyStimulus(4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd4, extraEdges, readyLowOk);
    checkOp("AND", 32'h00F0_00F0, 1'b0, 1'b0, 1'b0, 5'd4, 0);
    applyStimulus(4'd3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd5, extraEdges, readyLowOk);
    checkOp("OR", 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0, 5'd5, 0);
    applyStimulus(4'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd6, extraEdges, readyLowOk);
    checkOp("XOR", 32'hFF00_FF00, 1'b0, 1'b0, 1'b0, 5'd6, 0);
    applyStimulus(4'd5, 32'hDEAD_BEEF, 32'h0, 5'd7, extraEdges, readyLowOk);
    checkOp("PASS", 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 5'd7, 0);
    applyStimulus(4'd6, 32'h100, 32'h0, 5'd8, extraEdges, readyLowOk);
    checkOp("LINK", 32'h104, 1'b0, 1'b0, 1'b0, 5'd8, 0);
    applyStimulus(4'd7, 32'h1, 32'h3F, 5'd9, extraEdges, readyLowOk);
    checkOp("SLL", 32'h8000_0000, 1'b0, 1'b0, 1'b0, 5'd9, 0);
    applyStimulus(4'd8, 32'h8000_0000, 32'h1F, 5'd10, extraEdges, readyLowOk);
    checkOp("SRL", 32'h1, 1'b0, 1'b0, 1'b0, 5'd10, 0);
    applyStimulus(4'd9, 32'h8000_0000, 32'h24, 5'd11, extraEdges, readyLowOk);
    checkOp("SRA", 32'hF800_0000, 1'b0, 1'b0, 1'b0, 5'd11, 0);
    applyStimulus(4'd10, 32'hFFFF_FFFF, 32'h1, 5'd12, extraEdges, readyLowOk);
    checkOp("SLT", 32'h1, 1'b0, 1'b0, 1'b0, 5'd12, 0);
    applyStimulus(4'd11, 32'hFFFF_FFFF, 32'h1, 5'd13, extraEdges, readyLowOk);
    checkOp("SLTU", 32'h0, 1'b0, 1'b0, 1'b0, 5'd13, 0);

    // Iterative multiply: 32 edges to result, in_ready low meanwhile
    applyStimulus(4'd12, 32'h0001_0000, 32'h0001_0000, 5'd14, extraEdges, readyLowOk);
    checkOp("MUL", 32'h0, 1'b0, 1'b0, 1'b0, 5'd14, 32);
    checkOutput("MUL in_ready low", 64'(readyLowOk), 64'd1);
    applyStimulus(4'd13, 32'h0001_0000, 32'h0001_0000, 5'd15, extraEdges, readyLowOk);
    checkOp("MULHU", 32'h1, 1'b0, 1'b0, 1'b0, 5'd15, 32);
    applyStimulus(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd16, extraEdges, readyLowOk);
    checkOp("MUL max", 32'h1, 1'b0, 1'b0, 1'b0, 5'd16, 32);
    applyStimulus(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, extraEdges, readyLowOk);
    checkOp("MULHU max", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 5'd17, 32);

    // Divide, including divide by zero
    applyStimulus(4'd14, 32'd100, 32'd7, 5'd18, extraEdges, readyLowOk);
    checkOp("DIVU", DIV_EN ? 32'd14 : 32'd0, 1'b0, 1'b0, !DIV_EN, 5'd18, DIV_EN ? 32 : 0);
    applyStimulus(4'd15, 32'd100, 32'd7, 5'd19, extraEdges, readyLowOk);
    checkOp("REMU", DIV_EN ? 32'd2 : 32'd0, 1'b0, 1'b0, !DIV_EN, 5'd19, DIV_EN ? 32 : 0);
    applyStimulus(4'd14, 32'hFFFF_FFFF, 32'h10, 5'd20, extraEdges, readyLowOk);
    checkOp("DIVU big", DIV_EN ? 32'h0FFF_FFFF : 32'd0, 1'b0, 1'b0, !DIV_EN, 5'd20, DIV_EN ? 32 : 0);
    applyStimulus(4'd15, 32'hFFFF_FFFF, 32'h10, 5'd21, extraEdges, readyLowOk);
    checkOp("REMU big", DIV_EN ? 32'hF : 32'd0, 1'b0, 1'b0, !DIV_EN, 5'd21, DIV_EN ? 32 : 0);
    applyStimulus(4'd14, 32'd5, 32'd0, 5'd22, extraEdges, readyLowOk);
    checkOp("DIVU by 0", DIV_EN ? 32'hFFFF_FFFF : 32'd0, 1'b0, 1'b0, !DIV_EN, 5'd22, 0);
    applyStimulus(4'd15, 32'd5, 32'd0, 5'd23, extraEdges, readyLowOk);
    checkOp("REMU by 0", DIV_EN ? 32'd5 : 32'd0, 1'b0, 1'b0, !DIV_EN, 5'd23, 0);

    // Back-pressure: hold the ADD result, then hand off and accept on one edge
    tick();
    out_ready = 1'b0;
    applyStimulus(4'd0, 32'd7, 32'd8, 5'd3, extraEdges, readyLowOk);
    checkOp("BP ADD", 32'd15, 1'b0, 1'b0, 1'b0, 5'd3, 0);
    op       = 4'd1;
    a        = 32'd10;
    b        = 32'd3;
    in_tag   = 5'd4;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("BP in_ready", 64'(in_ready), 64'd0);
      checkOutput("BP out_valid", 64'(out_valid), 64'd1);
      checkOutput("BP result", 64'(result), 64'd15);
      checkOutput("BP out_tag", 64'(out_tag), 64'd3);
      tick();
    end
    out_ready = 1'b1;
    #1;
    checkOutput("BP release in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    checkOutput("BP new result", 64'(result), 64'd7);
    checkOutput("BP new tag", 64'(out_tag), 64'd4);
    checkOutput("BP new valid", 64'(out_valid), 64'd1);
    tick();
    checkOutput("BP drained", 64'(out_valid), 64'd0);

    // Reset in the middle of a multiply
    op       = 4'd12;
    a        = 32'd3;
    b        = 32'd5;
    in_tag   = 5'd30;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    checkOutput("MID in_ready busy", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("MID rst result", 64'(result), 64'd0);
    checkOutput("MID rst tag", 64'(out_tag), 64'd0);
    checkOutput("MID rst zero", 64'(zero), 64'd1);
    checkOutput("MID rst carry", 64'(carry), 64'd0);
    checkOutput("MID rst valid", 64'(out_valid), 64'd0);
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("MID release in_ready", 64'(in_ready), 64'd1);
    applyStimulus(4'd0, 32'd2, 32'd3, 5'd9, extraEdges, readyLowOk);
    checkOp("POST ADD", 32'd5, 1'b0, 1'b0, 1'b0, 5'd9, 0);
    tick();
    for (int i = 0; i < 40; i++) begin
      if (out_valid) checkOutput("POST stale result", 64'(out_valid), 64'd0);
      tick();
    end
    checkOutput("POST idle", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
